beep_sequencer: RTL

BEEP_SEQUENCER -- requirements
Module: beep_sequencer

---
 rtl/beep_sequencer_pkg.sv | 16 +
 rtl/beep_sequencer_channel.sv | 186 ++++++++++++++++++
 rtl/beep_sequencer.sv | 64 ++++++
 3 files changed

// File: rtl/beep_sequencer_pkg.sv
// Shared definitions for the beep sequencer: mode encodings and the
// per-channel FSM state type.
package beep_sequencer_pkg;

  localparam logic [1:0] MODE_CONT  = 2'd0;
  localparam logic [1:0] MODE_GATED = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } beep_state_e;

endpackage

// File: rtl/beep_sequencer_channel.sv
// One tone channel: IDLE/ON/OFF sequencer with a private tick prescaler,
// a half-period counter for the square wave, a duration counter and a beep counter.
module beep_channel
  import beep_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int HALF_W   = 16,
  parameter int TIME_W   = 12,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [HALF_W-1:0] half_period,
  input  logic [TIME_W-1:0] on_time,
  input  logic [TIME_W-1:0] off_time,
  input  logic [CNT_W-1:0]  beep_cnt,
  output logic              tone,
  output logic              tone_next,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  beep_state_e       state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [TIME_W-1:0] on_q, on_d;
  logic [TIME_W-1:0] off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TIME_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0]  beeps_q, beeps_d;
  logic              tone_q, tone_d;
  logic              done_q, done_d;

  logic [TIME_W-1:0] cur_dur;
  logic              window_end;

  // A zero duration behaves as one tick, so the window ends on the first tick.
  always_comb begin
    cur_dur    = (state_q == ST_OFF) ? off_q : on_q;
    window_end = (tick_q == TICK_LAST) &&
                 ((cur_dur == '0) || (dur_q == cur_dur - TIME_W'(1)));
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    half_d     = half_q;
    on_d       = on_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    half_cnt_d = half_cnt_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    beeps_d    = beeps_q;
    tone_d     = tone_q;
    done_d     = 1'b0;

    if (stop) begin
      state_d    = ST_IDLE;
      tone_d     = 1'b0;
      half_cnt_d = '0;
      tick_d     = '0;
      dur_d      = '0;
      beeps_d    = '0;
    end else if (start && (mode != MODE_RSVD)) begin
      mode_d     = mode;
      half_d     = half_period;
      on_d       = on_time;
      off_d      = off_time;
      cnt_d      = beep_cnt;
      half_cnt_d = '0;
      tick_d     = '0;
      dur_d      = '0;
      beeps_d    = '0;
      if ((mode == MODE_BURST) && (beep_cnt == '0)) begin
        state_d = ST_IDLE;
        tone_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_ON;
        tone_d  = (half_period != '0);
      end
    end else begin
      case (state_q)
        ST_ON: begin
          if (half_q == '0) begin
            tone_d = 1'b0;
          end else if (half_cnt_q == half_q - HALF_W'(1)) begin
            tone_d     = ~tone_q;
            half_cnt_d = '0;
          end else begin
            half_cnt_d = half_cnt_q + HALF_W'(1);
          end
          // Continuous mode holds ON indefinitely, so its timers stay parked.
          if (mode_q != MODE_CONT) begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              dur_d  = dur_q + TIME_W'(1);
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
            if (window_end) begin
              tick_d     = '0;
              dur_d      = '0;
              half_cnt_d = '0;
              tone_d     = 1'b0;
              if ((mode_q == MODE_BURST) && (beeps_q == cnt_q - CNT_W'(1))) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                beeps_d = '0;
              end else begin
                state_d = ST_OFF;
                if (mode_q == MODE_BURST) begin
                  beeps_d = beeps_q + CNT_W'(1);
                end
              end
            end
          end
        end
        ST_OFF: begin
          tone_d = 1'b0;
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            dur_d  = dur_q + TIME_W'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          if (window_end) begin
            tick_d     = '0;
            dur_d      = '0;
            half_cnt_d = '0;
            state_d    = ST_ON;
            tone_d     = (half_q != '0);
          end
        end
        default: begin
          tone_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      half_q     <= '0;
      on_q       <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      half_cnt_q <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
      beeps_q    <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
      on_q       <= on_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      half_cnt_q <= half_cnt_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      beeps_q    <= beeps_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  assign tone      = tone_q;
  assign tone_next = tone_d;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: rtl/beep_sequencer.sv
// Multi-channel beep/tone sequencer: NUM_CH independent channels plus a
// registered OR of all tone outputs.
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int TICK_DIV = 1000,
  parameter int HALF_W   = 16,
  parameter int TIME_W   = 12,
  parameter int CNT_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [2*NUM_CH-1:0]      mode,
  input  logic [HALF_W*NUM_CH-1:0] half_period,
  input  logic [TIME_W*NUM_CH-1:0] on_time,
  input  logic [TIME_W*NUM_CH-1:0] off_time,
  input  logic [CNT_W*NUM_CH-1:0]  beep_cnt,
  output logic [NUM_CH-1:0]        tone,
  output logic                     tone_mix,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done
);

  logic [NUM_CH-1:0] tone_next;
  logic              tone_mix_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    beep_channel #(
      .TICK_DIV (TICK_DIV),
      .HALF_W   (HALF_W),
      .TIME_W   (TIME_W),
      .CNT_W    (CNT_W)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .start       (start[ch]),
      .stop        (stop[ch]),
      .mode        (mode[2*ch +: 2]),
      .half_period (half_period[HALF_W*ch +: HALF_W]),
      .on_time     (on_time[TIME_W*ch +: TIME_W]),
      .off_time    (off_time[TIME_W*ch +: TIME_W]),
      .beep_cnt    (beep_cnt[CNT_W*ch +: CNT_W]),
      .tone        (tone[ch]),
      .tone_next   (tone_next[ch]),
      .busy        (busy[ch]),
      .done        (done[ch])
    );
  end

  // Built from each channel's next tone so the mix updates on the same edge as the tone bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_mix_q <= 1'b0;
    end else begin
      tone_mix_q <= |tone_next;
    end
  end

  assign tone_mix = tone_mix_q;

endmodule
